// File: rtl/l2_seq_pkg.sv
// rtl/l2_seq_pkg.sv - shared state enum and precision codes for the L2 MAC sequencer
package l2_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } l2_seq_state_e;

  localparam logic [1:0] PREC_8B = 2'b00;
  localparam logic [1:0] PREC_4B = 2'b10;
  localparam logic [1:0] PREC_2B = 2'b11;

endpackage

// File: rtl/l2_seq_cnt.sv
// rtl/l2_seq_cnt.sv - loadable down-counter with zero flag, shared by wait phases and beat count
module l2_seq_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load wins over decrement; the count parks at zero instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/l2_mac_seq.sv
// rtl/l2_mac_seq.sv - one-job MAC sequencer; L2_SEQ_STALL_CNT_EN adds a RUN stall counter
module l2_mac_seq
  import l2_seq_pkg::*;
#(
  parameter int N_A     = 1,
  parameter int N_W     = 1,
  parameter int Z_W     = 20,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [3:0]         i_cfg_prec,
  input  logic [LEN_W-1:0]   i_cfg_len,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [8*N_A-1:0]   i_in_a,
  input  logic [8*N_W-1:0]   i_in_w,
  output logic               o_mac_rst,
  output logic [3:0]         o_mac_prec,
  output logic [8*N_A-1:0]   o_mac_a,
  output logic [8*N_W-1:0]   o_mac_w,
  input  logic [Z_W-1:0]     i_mac_z,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [Z_W-1:0]     o_out_z,
  output logic               o_busy
`ifdef L2_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]        o_stall_cnt
`endif
);

  localparam int CNT_W = (LEN_W > $clog2(MAC_LAT + 1)) ? LEN_W : $clog2(MAC_LAT + 1);

  l2_seq_state_e      r_state;
  l2_seq_state_e      w_next_state;
  logic [3:0]         r_prec;
  logic [LEN_W-1:0]   r_len;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [Z_W-1:0]     r_out_z;
  logic               r_mac_rst;
  logic [3:0]         r_mac_prec;
  logic [8*N_A-1:0]   r_mac_a;
  logic [8*N_W-1:0]   r_mac_w;
  logic               w_accept;
  logic               w_start_job;
  logic               w_cnt_load;
  logic [CNT_W-1:0]   w_cnt_val;
  logic               w_cnt_dec;
  logic               w_cnt_zero;
  logic [3:0]         w_prec_next;

  l2_seq_cnt #(.W(CNT_W)) u_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // CLEAR waits MAC_LAT cycles (load MAC_LAT-1); DRAIN loads MAC_LAT so the
  // extra cycle lets mac_z settle before the capture edge.
  always_comb begin
    w_next_state = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_val    = '0;
    w_cnt_dec    = 1'b0;
    w_accept     = (r_state == ST_RUN) && i_in_valid;
    w_start_job  = (r_state == ST_IDLE) && i_start;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_state = ST_CLEAR;
          w_cnt_load   = 1'b1;
          w_cnt_val    = CNT_W'(MAC_LAT - 1);
        end
      end
      ST_CLEAR: begin
        if (!w_cnt_zero) begin
          w_cnt_dec = 1'b1;
        end else if (r_len == '0) begin
          w_next_state = ST_DRAIN;
          w_cnt_load   = 1'b1;
          w_cnt_val    = CNT_W'(MAC_LAT);
        end else begin
          w_next_state = ST_RUN;
          w_cnt_load   = 1'b1;
          w_cnt_val    = CNT_W'(r_len - LEN_W'(1));
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          if (w_cnt_zero) begin
            w_next_state = ST_DRAIN;
            w_cnt_load   = 1'b1;
            w_cnt_val    = CNT_W'(MAC_LAT);
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (w_cnt_zero) begin
          w_next_state = ST_OUT;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_OUT: begin
        if (i_out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign w_prec_next = (r_state == ST_IDLE) ? i_cfg_prec : r_prec;

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prec      <= '0;
      r_len       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_z     <= '0;
      r_mac_rst   <= 1'b1;
      r_mac_prec  <= '0;
      r_mac_a     <= '0;
      r_mac_w     <= '0;
    end else begin
      if (w_start_job) begin
        r_prec <= i_cfg_prec;
        r_len  <= i_cfg_len;
      end
      r_in_ready  <= (w_next_state == ST_RUN);
      r_out_valid <= (w_next_state == ST_OUT);
      r_mac_rst   <= (w_next_state == ST_CLEAR);
      r_mac_prec  <= (w_next_state == ST_IDLE) ? 4'd0 : w_prec_next;
      r_mac_a     <= w_accept ? i_in_a : '0;
      r_mac_w     <= w_accept ? i_in_w : '0;
      if ((r_state == ST_DRAIN) && w_cnt_zero) begin
        r_out_z <= i_mac_z;
      end
    end
  end

`ifdef L2_SEQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_job) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_RUN) && !i_in_valid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_z     = r_out_z;
  assign o_mac_rst   = r_mac_rst;
  assign o_mac_prec  = r_mac_prec;
  assign o_mac_a     = r_mac_a;
  assign o_mac_w     = r_mac_w;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_l2_mac_seq.sv
// tb/tb_l2_mac_seq.sv - self-checking bench for l2_mac_seq with a 3-stage MAC fixture
module tb_l2_mac_seq;
  import l2_seq_pkg::*;

  localparam int MAC_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  cfg_prec;
  logic [7:0]  cfg_len;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_w;
  logic        mac_rst;
  logic [3:0]  mac_prec;
  logic [7:0]  mac_a;
  logic [7:0]  mac_w;
  logic [19:0] mac_z;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_z;
  logic        busy;
`ifdef L2_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad = 0;
  byte beat_a[$];
  byte beat_w[$];

  always #5 clk = ~clk;

  l2_mac_seq #(.N_A(1), .N_W(1), .Z_W(20), .LEN_W(8), .MAC_LAT(MAC_LAT)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_cfg_prec (cfg_prec),
    .i_cfg_len  (cfg_len),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_a     (in_a),
    .i_in_w     (in_w),
    .o_mac_rst  (mac_rst),
    .o_mac_prec (mac_prec),
    .o_mac_a    (mac_a),
    .o_mac_w    (mac_w),
    .i_mac_z    (mac_z),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_z    (out_z),
    .o_busy     (busy)
`ifdef L2_SEQ_STALL_CNT_EN
    ,
    .o_stall_cnt(stall_cnt)
`endif
  );

  // MAC wrapper stand-in: input register, product register, accumulator.
  logic signed [7:0]  m_a, m_w;
  logic signed [15:0] m_p;
  logic signed [19:0] m_acc;
  always @(posedge clk) begin
    if (mac_rst) begin
      m_a <= '0; m_w <= '0; m_p <= '0; m_acc <= '0;
    end else begin
      m_a   <= mac_a;
      m_w   <= mac_w;
      m_p   <= m_a * m_w;
      m_acc <= m_acc + {{4{m_p[15]}}, m_p};
    end
  end
  assign mac_z = m_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ref_sum();
    int s = 0;
    for (int i = 0; i < beat_a.size(); i++) s += int'(beat_a[i]) * int'(beat_w[i]);
    return s[19:0];
  endfunction

  task automatic fill(input int len, input byte a, input byte w, input bit rnd);
    beat_a.delete(); beat_w.delete();
    for (int i = 0; i < len; i++) begin
      beat_a.push_back(rnd ? byte'($urandom) : a);
      beat_w.push_back(rnd ? byte'($urandom) : w);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the first negedge with out_valid=1.
  task automatic run_job(input int len, input int vmode, input logic [3:0] prec,
                         output logic [19:0] z, output int lat, output int bub);
    int fed; bit tog; bit v;
    fed = 0; tog = 1'b1; bub = 0; lat = -1; z = '0;
    start = 1'b1; cfg_prec = prec; cfg_len = 8'(len);
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      cfg_prec = 4'($urandom);
      cfg_len = 8'($urandom);
      if (out_valid) begin
        lat = c; z = out_z;
        break;
      end
      check("mac_prec_latched", 32'(mac_prec), 32'(prec));
      if (len == 0) check("zero_len_ops", {16'b0, mac_a, mac_w}, 32'd0);
      if (in_ready && fed < len) begin
        v = (vmode == 0) ? 1'b1 : (vmode == 1) ? tog : 1'($urandom_range(0, 1));
        tog = ~tog;
        in_valid = v;
        in_a = v ? beat_a[fed] : 8'($urandom);
        in_w = v ? beat_w[fed] : 8'($urandom);
        if (v) fed++; else bub++;
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_a = 8'($urandom);
        in_w = 8'($urandom);
      end
    end
    start = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    logic [19:0] z;
    logic [19:0] ez;
    int lat, bub, len, n;
    logic [3:0] p;

    rst_n = 1'b0; start = 1'b0; cfg_prec = '0; cfg_len = '0;
    in_valid = 1'b0; in_a = '0; in_w = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_z", 32'(out_z), 32'd0);
    check("rst_mac_rst", 32'(mac_rst), 32'd1);
    check("rst_ops", {16'b0, mac_a, mac_w}, 32'd0);
    check("rst_mac_prec", 32'(mac_prec), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic job: 4 x (3*5)
    fill(4, 8'sd3, 8'sd5, 1'b0);
    run_job(4, 0, {PREC_8B, PREC_8B}, z, lat, bub);
    check("basic_z", 32'(z), 32'd60);
    check("basic_latency", 32'(lat), 32'(2 + 2 * MAC_LAT + 4));
    @(negedge clk);
    check("basic_one_cycle_valid", 32'(out_valid), 32'd0);
    check("basic_idle", 32'(busy), 32'd0);
    check("idle_mac_prec", 32'(mac_prec), 32'd0);

    // Bubbles: valid toggles 1,0,1,...
    run_job(4, 1, {PREC_8B, PREC_8B}, z, lat, bub);
    check("bubble_z", 32'(z), 32'd60);
    check("bubble_latency", 32'(lat), 32'(2 + 2 * MAC_LAT + 4 + 3));
`ifdef L2_SEQ_STALL_CNT_EN
    check("bubble_stall_cnt", 32'(stall_cnt), 32'd3);
`endif
    @(negedge clk);

    // Zero length
    fill(0, 8'sd0, 8'sd0, 1'b0);
    run_job(0, 0, {PREC_4B, PREC_2B}, z, lat, bub);
    check("zero_len_z", 32'(z), 32'd0);
    check("zero_len_latency", 32'(lat), 32'(2 + 2 * MAC_LAT));
    @(negedge clk);

    // Backpressure, ignored start, then back-to-back job
    out_ready = 1'b0;
    fill(4, 8'sd3, 8'sd5, 1'b0);
    run_job(4, 0, {PREC_8B, PREC_8B}, z, lat, bub);
    check("bp_z", 32'(z), 32'd60);
    for (int i = 0; i < 10; i++) begin
      start = 1'b1; cfg_len = 8'($urandom);
      @(negedge clk);
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_z_stable", 32'(out_z), 32'd60);
      check("bp_mac_rst_low", 32'(mac_rst), 32'd0);
    end
    start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_idle", 32'(busy), 32'd0);
    fill(2, 8'sd7, -8'sd1, 1'b0);
    run_job(2, 0, {PREC_8B, PREC_8B}, z, lat, bub);
    check("b2b_z", 32'(z), 32'(20'hFFFF2));
    check("b2b_latency", 32'(lat), 32'(2 + 2 * MAC_LAT + 2));
    @(negedge clk);

    // Reset mid-RUN after 2 of 4 beats
    start = 1'b1; cfg_len = 8'd4; cfg_prec = '0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 50 && n < 2; c++) begin
      if (in_ready) begin
        in_valid = 1'b1; in_a = 8'd3; in_w = 8'd5; n++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("mid_rst_beats_fed", 32'(n), 32'd2);
    check("mid_rst_running", 32'(in_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_idle", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_mac_rst", 32'(mac_rst), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(4, 8'sd3, 8'sd5, 1'b0);
    run_job(4, 0, {PREC_8B, PREC_8B}, z, lat, bub);
    check("post_rst_z", 32'(z), 32'd60);
    @(negedge clk);

    // Randomized jobs against the sum-of-products reference
    for (int j = 0; j < 8; j++) begin
      len = $urandom_range(0, 12);
      p = 4'($urandom);
      fill(len, 8'sd0, 8'sd0, 1'b1);
      ez = ref_sum();
      run_job(len, 2, p, z, lat, bub);
      check("rand_z", 32'(z), 32'(ez));
      check("rand_latency", 32'(lat), 32'(2 + 2 * MAC_LAT + len + bub));
`ifdef L2_SEQ_STALL_CNT_EN
      check("rand_stall_cnt", 32'(stall_cnt), 32'(bub));
`endif
      @(negedge clk);
      check("rand_idle", 32'(busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_mac_seq.md
# l2_mac_seq

Sequencer that runs one accumulation job on the registered L2 MAC wrapper. It accepts a job command (precision, beat count), streams operand beats from an upstream valid/ready source into the MAC, and clears the accumulator before the job. After the last beat it drains the MAC pipeline, then holds the result for a downstream valid/ready consumer. It sits between the operand fetch logic and the MAC wrapper, and is the only block that drives the MAC's reset, precision and operand inputs.

## Interface
- `N_A`, 1: activation lanes per beat; equals the MAC's A-input count for the chosen MODE/BG/DVAFS.
- `N_W`, 1: weight lanes per beat; equals the MAC's W-input count.
- `Z_W`, 20: MAC result width.
- `LEN_W`, 8: beat-count width.
- `MAC_LAT`, 3: cycles from operands on `mac_a`/`mac_w` until `mac_z` includes them, counting the wrapper's input register.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: job request; sampled only in IDLE.
- `cfg_prec` input 4: precision code ({act, wgt}: 00 = 8b, 10 = 4b, 11 = 2b); latched at start.
- `cfg_len` input LEN_W: number of operand beats; latched at start.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: operand beat accepted.
- `in_a` input 8×N_A: activation lanes.
- `in_w` input 8×N_W: weight lanes.
- `mac_rst` output 1: active-high clear to the MAC wrapper.
- `mac_prec` output 4: precision to the MAC.
- `mac_a` output 8×N_A: activation lanes to the MAC.
- `mac_w` output 8×N_W: weight lanes to the MAC.
- `mac_z` input Z_W: MAC accumulator output.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `out_z` output Z_W: captured result.
- `busy` output 1: state is not IDLE.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, OUT.
- IDLE:
  - `start`=1 latches `cfg_prec`/`cfg_len` and moves to CLEAR.
  - If `cfg_len`=0, the job still passes through CLEAR and DRAIN, skips RUN, and produces `out_z`=0.
- CLEAR:
  - `mac_rst`=1 and operands are zero.
  - Stays for MAC_LAT cycles so the clear reaches the accumulator, then moves to RUN (or to DRAIN if the length is 0).
- RUN:
  - `in_ready`=1.
  - Each cycle with `in_valid`: `mac_a`/`mac_w` = `in_a`/`in_w`, and the remaining-beat counter decrements.
  - Each cycle without `in_valid`: `mac_a`/`mac_w` = 0 (a bubble adds 0).
  - The accepted beat that brings the counter to 0 moves the FSM to DRAIN.
- DRAIN: operands are zero for MAC_LAT cycles, then `mac_z` is captured into `out_z` and the FSM moves to OUT.
- OUT:
  - `out_valid`=1; `out_z` is held stable.
  - `out_valid`∧`out_ready` returns the FSM to IDLE.
  - `mac_rst` is not asserted here; the accumulator keeps its value until the next CLEAR.
- `mac_prec` = latched precision in every non-IDLE state and 0 in IDLE; it never changes mid-job.
- `start` outside IDLE is ignored; there is no queueing.
- Arithmetic: `out_z` is `mac_z` unmodified. Overflow beyond the MAC headroom is the caller's responsibility.
- Reset values: state IDLE, `in_ready`=0, `out_valid`=0, `out_z`=0, `mac_rst`=1, operands 0, `mac_prec`=0, `busy`=0.
- Reset mid-job: async return to IDLE; any partial result is discarded; `mac_rst` is held high while `rst_n` is low.

## Timing
- `in_ready` is a registered state decode; it does not depend combinationally on `in_valid`.
- `mac_*` outputs are registered, so an operand accepted in cycle t appears on `mac_a`/`mac_w` at t+1.
- Latency, start to `out_valid`, with no bubbles: 1 + MAC_LAT (CLEAR) + `cfg_len` (RUN) + MAC_LAT (DRAIN) + 1 (capture) cycles.
- `out_valid` rises on the first OUT cycle. If `out_ready` is already high, `out_valid` is 1 for exactly one cycle.
- Back-to-back jobs: `start` in the cycle right after the OUT handshake is accepted (IDLE lasts ≥1 cycle).

## Configuration
- `L2_SEQ_STALL_CNT_EN` defined:
  - Adds output `stall_cnt` [15:0]: number of RUN cycles with `in_valid`=0 in the current job.
  - Cleared on entry to CLEAR; saturates at 16'hFFFF; frozen outside RUN.
- `L2_SEQ_STALL_CNT_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `l2_seq_pkg`:
  - state enum `l2_seq_state_e`;
  - precision code constants `PREC_8B`=2'b00, `PREC_4B`=2'b10, `PREC_2B`=2'b11.
- N_A, N_W and Z_W are computed by the instantiating level with the existing helper functions; this block does not call them.
- One natural sub-module, `l2_seq_cnt`: a loadable down-counter with zero flag, shared by the CLEAR/DRAIN wait and the RUN beat count.

## Test plan
- Bench configuration: N_A=N_W=1, 8×8 precision.
- Basic job: `cfg_len`=4, `in_a`=3, `in_w`=5 on every beat, `in_valid` always 1 -> `out_z`=60; `out_valid` rises 2+2·MAC_LAT+4 cycles after `start`.
- Bubbles: same job with `in_valid` toggling 1,0,1,0… -> `out_z`=60; with the macro, `stall_cnt`=3.
- Zero length: `cfg_len`=0 -> `out_z`=0; `mac_a`/`mac_w` stay 0 throughout.
- Backpressure and back-to-back:
  - hold `out_ready`=0 for 10 cycles -> `out_z` stable, `start` ignored;
  - release -> IDLE; a second job (`cfg_len`=2, a=7, w=−1 as 8'hFF signed) gives `out_z`=−14.
- Reset mid-RUN: drop `rst_n` after 2 of 4 beats -> same cycle IDLE, `in_ready`=0, `mac_rst`=1; a fresh 4-beat job then yields 60, not residue-affected.
- Precision latch: change `cfg_prec` during RUN -> `mac_prec` unchanged until the next `start`.
